// File: rtl/elevator_car_plant_if.sv
// Command/sensor bundle between the elevator controller and the car plant.
// The master is the controller; the slave is the plant.
interface elevator_car_plant_if #(
    parameter int FLOORS = 8
);
    logic              motor_up;
    logic              motor_down;
    logic              motor_brake;
    logic              door_open_cmd;
    logic              door_close_cmd;
    logic              door_obstruct;
    logic [FLOORS-1:0] floor_sensor;
    logic              door_open_sensor;
    logic              door_closed_sensor;
    logic [2:0]        car_floor;
    logic              at_level;
    logic              car_moving;
    logic [2:0]        fault_flags;

    modport master (
        output motor_up, motor_down, motor_brake,
        output door_open_cmd, door_close_cmd, door_obstruct,
        input  floor_sensor, door_open_sensor, door_closed_sensor,
        input  car_floor, at_level, car_moving, fault_flags
    );

    modport slave (
        input  motor_up, motor_down, motor_brake,
        input  door_open_cmd, door_close_cmd, door_obstruct,
        output floor_sensor, door_open_sensor, door_closed_sensor,
        output car_floor, at_level, car_moving, fault_flags
    );
endinterface

// File: rtl/elevator_car_plant.sv
// Elevator car, hoist and door plant model. Integrates motor commands into a
// tick-resolution car position, moves the door, and latches unsafe command
// combinations as sticky faults. All outputs come from registers.
module elevator_car_plant #(
    parameter int FLOORS      = 8,
    parameter int TICK_BITS   = 4,
    parameter int MOVE_DIV    = 4,
    parameter int DOOR_TICKS  = 10,
    parameter int START_FLOOR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    elevator_car_plant_if.slave  bus
);
    localparam int TPF = 1 << TICK_BITS;
    localparam int PW  = 3 + TICK_BITS;
    localparam int PDW = $clog2(MOVE_DIV);
    localparam int DW  = $clog2(DOOR_TICKS + 1);

    localparam logic [PW-1:0]  POS_MAX = PW'((FLOORS - 1) * TPF);
    localparam logic [PW-1:0]  POS_RST = PW'(START_FLOOR * TPF);
    localparam logic [PDW-1:0] PD_LAST = PDW'(MOVE_DIV - 1);
    localparam logic [DW-1:0]  D_OPEN  = DW'(DOOR_TICKS);

    logic [PW-1:0]  pos;
    logic [PW-1:0]  pos_nxt;
    logic [PDW-1:0] pdiv;
    logic [DW-1:0]  door_pos;
    logic [2:0]     land;
    logic [2:0]     flt;
    logic [2:0]     flt_set;
    logic           moving_q;
    logic           lvl;
    logic           dclosed;
    logic           mv_up;
    logic           mv_dn;
    logic           mv;
    logic           step;
    logic           door_inc;
    logic           door_dec;

    // Motion enables, position step, door drive and fault detection.
    always_comb begin
        lvl      = (pos[TICK_BITS-1:0] == '0);
        dclosed  = (door_pos == '0);
        mv_up    = bus.motor_up & ~bus.motor_down & ~bus.motor_brake & dclosed & (pos < POS_MAX);
        mv_dn    = bus.motor_down & ~bus.motor_up & ~bus.motor_brake & dclosed & (pos > '0);
        mv       = mv_up | mv_dn;
        step     = mv & (pdiv == PD_LAST);
        pos_nxt  = pos;
        if (step)
            pos_nxt = mv_up ? pos + PW'(1) : pos - PW'(1);
        // Opening needs a level, stationary car; an obstruction only freezes closing.
        door_inc = bus.door_open_cmd & ~bus.door_close_cmd & lvl & ~mv;
        door_dec = bus.door_close_cmd & ~bus.door_open_cmd & ~bus.door_obstruct;
        flt_set  = '0;
        flt_set[0] = bus.motor_up & bus.motor_down;
        flt_set[1] = ((bus.motor_up | bus.motor_down) & ~bus.motor_brake & ~dclosed)
                   | (bus.door_open_cmd & ~lvl);
        flt_set[2] = (bus.motor_up & ~bus.motor_brake & (pos == POS_MAX))
                   | (bus.motor_down & ~bus.motor_brake & (pos == '0));
    end

    // Plant state: position, prescaler, landing latch, door, faults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= POS_RST;
            pdiv     <= '0;
            land     <= 3'(START_FLOOR);
            door_pos <= '0;
            flt      <= '0;
            moving_q <= 1'b0;
        end else begin
            // Prescaler restarts from zero whenever motion is interrupted.
            if (!mv)       pdiv <= '0;
            else if (step) pdiv <= '0;
            else           pdiv <= pdiv + PDW'(1);
            pos <= pos_nxt;
            // Latch only on reaching a level; between floors keep the last landing.
            if (pos_nxt[TICK_BITS-1:0] == '0)
                land <= pos_nxt[PW-1:TICK_BITS];
            if (door_inc && door_pos != D_OPEN)
                door_pos <= door_pos + DW'(1);
            else if (door_dec && !dclosed)
                door_pos <= door_pos - DW'(1);
            flt      <= flt | flt_set;
            moving_q <= mv;
        end
    end

    // One-hot landing decode.
    always_comb begin
        bus.floor_sensor = '0;
        for (int i = 0; i < FLOORS; i++)
            bus.floor_sensor[i] = (land == 3'(i));
    end

    assign bus.car_floor          = land;
    assign bus.at_level           = lvl;
    assign bus.car_moving         = moving_q;
    assign bus.door_closed_sensor = dclosed;
    assign bus.door_open_sensor   = (door_pos == D_OPEN);
    assign bus.fault_flags        = flt;
endmodule

// File: tb/tb_elevator_car_plant.sv
// Self-checking bench for elevator_car_plant: directed scenarios from the
// plant's behaviour description plus randomized command segments compared
// against an integer-arithmetic plant model.
module tb_elevator_car_plant;
    localparam int FLOORS = 8, TPF = 16, MOVE_DIV = 4, DOOR_TICKS = 10, START_FLOOR = 0;
    localparam int MAXP = (FLOORS - 1) * TPF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    elevator_car_plant_if #(.FLOORS(FLOORS)) bus();

    elevator_car_plant #(
        .FLOORS(FLOORS), .TICK_BITS(4), .MOVE_DIV(MOVE_DIV),
        .DOOR_TICKS(DOOR_TICKS), .START_FLOOR(START_FLOOR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: car position in ticks, motion cycle count, door travel.
    int         m_pos, m_run, m_door, m_land;
    bit         m_mv;
    logic [2:0] m_flt;

    task automatic model_reset();
        m_pos = START_FLOOR * TPF; m_run = 0; m_door = 0;
        m_land = START_FLOOR; m_mv = 0; m_flt = '0;
    endtask

    task automatic drive(input bit up, dn, brk, op, cl, ob);
        bus.motor_up = up; bus.motor_down = dn; bus.motor_brake = brk;
        bus.door_open_cmd = op; bus.door_close_cmd = cl; bus.door_obstruct = ob;
    endtask

    // Apply the current inputs for one clock and advance the model.
    task automatic step();
        bit up, dn, brk, op, cl, ob, level, go_up, go_dn;
        int n_pos, n_run, n_door;
        up = bus.motor_up; dn = bus.motor_down; brk = bus.motor_brake;
        op = bus.door_open_cmd; cl = bus.door_close_cmd; ob = bus.door_obstruct;
        level = (m_pos % TPF) == 0;
        go_up = up && !dn && !brk && m_door == 0 && m_pos < MAXP;
        go_dn = dn && !up && !brk && m_door == 0 && m_pos > 0;
        n_pos = m_pos; n_run = 0; n_door = m_door;
        // Every MOVE_DIV consecutive moving cycles advance the car one tick.
        if (go_up || go_dn) begin
            n_run = m_run + 1;
            if (n_run == MOVE_DIV) begin
                n_run = 0;
                n_pos = m_pos + (go_up ? 1 : -1);
            end
        end
        if (op && !cl && level && !(go_up || go_dn)) n_door = (m_door < DOOR_TICKS) ? m_door + 1 : DOOR_TICKS;
        else if (cl && !op && !ob)                   n_door = (m_door > 0) ? m_door - 1 : 0;
        @(posedge clk);
        if (up && dn) m_flt[0] = 1'b1;
        if (((up || dn) && !brk && m_door != 0) || (op && !level)) m_flt[1] = 1'b1;
        if ((up && !brk && m_pos == MAXP) || (dn && !brk && m_pos == 0)) m_flt[2] = 1'b1;
        m_pos = n_pos; m_run = n_run; m_door = n_door; m_mv = go_up || go_dn;
        if (m_pos % TPF == 0) m_land = m_pos / TPF;
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checks++; if (bus.floor_sensor !== 8'b0000_0001) begin errors++; $display("FAIL rst_floor_sensor got %b exp %b", bus.floor_sensor, 8'b0000_0001); end
        checks++; if (bus.car_floor !== 3'd0) begin errors++; $display("FAIL rst_car_floor got %0d exp 0", bus.car_floor); end
        checks++; if (bus.door_closed_sensor !== 1'b1 || bus.door_open_sensor !== 1'b0) begin errors++; $display("FAIL rst_door got closed=%b open=%b exp 1/0", bus.door_closed_sensor, bus.door_open_sensor); end
        checks++; if (bus.at_level !== 1'b1 || bus.car_moving !== 1'b0) begin errors++; $display("FAIL rst_level got lvl=%b mov=%b exp 1/0", bus.at_level, bus.car_moving); end
        checks++; if (bus.fault_flags !== 3'b000) begin errors++; $display("FAIL rst_faults got %b exp 000", bus.fault_flags); end
        rst = 1'b0;
        model_reset();
        step();
        checks++; if (bus.floor_sensor !== 8'b0000_0001 || bus.at_level !== 1'b1) begin errors++; $display("FAIL post_rst_idle got fs=%b lvl=%b exp 00000001/1", bus.floor_sensor, bus.at_level); end
    endtask

    task automatic test_travel();
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        steps(3);
        checks++; if (bus.at_level !== 1'b1) begin errors++; $display("FAIL travel_level_3cyc got %b exp 1", bus.at_level); end
        steps(1);
        checks++; if (bus.at_level !== 1'b0 || bus.car_moving !== 1'b1) begin errors++; $display("FAIL travel_level_4cyc got lvl=%b mov=%b exp 0/1", bus.at_level, bus.car_moving); end
        steps(59);
        checks++; if (bus.floor_sensor !== 8'b0000_0001) begin errors++; $display("FAIL travel_fs_63cyc got %b exp 00000001", bus.floor_sensor); end
        steps(1);
        checks++; if (bus.floor_sensor !== 8'b0000_0010 || bus.at_level !== 1'b1) begin errors++; $display("FAIL travel_fs_64cyc got fs=%b lvl=%b exp 00000010/1", bus.floor_sensor, bus.at_level); end
        steps(384);
        checks++; if (bus.floor_sensor !== 8'b1000_0000 || bus.car_floor !== 3'd7) begin errors++; $display("FAIL travel_top got fs=%b cf=%0d exp 10000000/7", bus.floor_sensor, bus.car_floor); end
        checks++; if (bus.fault_flags !== 3'b000) begin errors++; $display("FAIL travel_top_nofault got %b exp 000", bus.fault_flags); end
        steps(20);
        checks++; if (bus.fault_flags !== 3'b100 || bus.car_moving !== 1'b0) begin errors++; $display("FAIL travel_overtravel got flt=%b mov=%b exp 100/0", bus.fault_flags, bus.car_moving); end
        checks++; if (bus.at_level !== 1'b1 || bus.floor_sensor !== 8'b1000_0000) begin errors++; $display("FAIL travel_saturate got lvl=%b fs=%b exp 1/10000000", bus.at_level, bus.floor_sensor); end
    endtask

    task automatic test_door();
        do_reset();
        drive(0, 0, 0, 1, 0, 0);
        steps(1);
        checks++; if (bus.door_closed_sensor !== 1'b0 || bus.door_open_sensor !== 1'b0) begin errors++; $display("FAIL door_first_step got closed=%b open=%b exp 0/0", bus.door_closed_sensor, bus.door_open_sensor); end
        steps(8);
        checks++; if (bus.door_open_sensor !== 1'b0) begin errors++; $display("FAIL door_open_9cyc got %b exp 0", bus.door_open_sensor); end
        steps(1);
        checks++; if (bus.door_open_sensor !== 1'b1) begin errors++; $display("FAIL door_open_10cyc got %b exp 1", bus.door_open_sensor); end
        drive(0, 0, 0, 0, 1, 1);
        steps(3);
        checks++; if (bus.door_open_sensor !== 1'b1) begin errors++; $display("FAIL door_obstruct_hold got %b exp 1", bus.door_open_sensor); end
        drive(0, 0, 0, 0, 1, 0);
        steps(9);
        checks++; if (bus.door_closed_sensor !== 1'b0) begin errors++; $display("FAIL door_close_12cyc got %b exp 0", bus.door_closed_sensor); end
        steps(1);
        checks++; if (bus.door_closed_sensor !== 1'b1) begin errors++; $display("FAIL door_close_13cyc got %b exp 1", bus.door_closed_sensor); end
        checks++; if (bus.fault_flags !== 3'b000) begin errors++; $display("FAIL door_nofault got %b exp 000", bus.fault_flags); end
    endtask

    task automatic test_interlock();
        do_reset();
        drive(0, 0, 0, 1, 0, 0);
        steps(DOOR_TICKS);
        drive(1, 0, 0, 0, 0, 0);
        steps(5);
        checks++; if (bus.car_moving !== 1'b0 || bus.at_level !== 1'b1 || bus.floor_sensor !== 8'b0000_0001) begin errors++; $display("FAIL interlock_nomove got mov=%b lvl=%b fs=%b exp 0/1/00000001", bus.car_moving, bus.at_level, bus.floor_sensor); end
        checks++; if (bus.fault_flags !== 3'b010) begin errors++; $display("FAIL interlock_fault got %b exp 010", bus.fault_flags); end
        drive(0, 0, 0, 0, 0, 0);
        steps(3);
        checks++; if (bus.fault_flags !== 3'b010) begin errors++; $display("FAIL interlock_sticky got %b exp 010", bus.fault_flags); end
    endtask

    task automatic test_conflict();
        do_reset();
        drive(1, 1, 0, 0, 0, 0);
        steps(6);
        checks++; if (bus.car_moving !== 1'b0 || bus.at_level !== 1'b1) begin errors++; $display("FAIL conflict_nomove got mov=%b lvl=%b exp 0/1", bus.car_moving, bus.at_level); end
        // At floor 0 the down half of the conflict is also an overtravel.
        checks++; if (bus.fault_flags !== 3'b101) begin errors++; $display("FAIL conflict_fault got %b exp 101", bus.fault_flags); end
        do_reset();
        drive(0, 1, 0, 0, 0, 0);
        steps(10);
        checks++; if (bus.fault_flags !== 3'b100) begin errors++; $display("FAIL bottom_overtravel got %b exp 100", bus.fault_flags); end
        checks++; if (bus.at_level !== 1'b1 || bus.car_floor !== 3'd0 || bus.car_moving !== 1'b0) begin errors++; $display("FAIL bottom_hold got lvl=%b cf=%0d mov=%b exp 1/0/0", bus.at_level, bus.car_floor, bus.car_moving); end
    endtask

    task automatic test_reset_midtravel();
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        steps(40 * MOVE_DIV);
        checks++; if (bus.car_floor !== 3'd2 || bus.at_level !== 1'b0 || bus.car_moving !== 1'b1) begin errors++; $display("FAIL mid_travel got cf=%0d lvl=%b mov=%b exp 2/0/1", bus.car_floor, bus.at_level, bus.car_moving); end
        #3;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.floor_sensor !== 8'b0000_0001 || bus.at_level !== 1'b1 || bus.car_moving !== 1'b0) begin errors++; $display("FAIL async_rst got fs=%b lvl=%b mov=%b exp 00000001/1/0", bus.floor_sensor, bus.at_level, bus.car_moving); end
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        steps(2);
        checks++; if (bus.car_floor !== 3'(START_FLOOR) || bus.at_level !== 1'b1 || bus.fault_flags !== 3'b000) begin errors++; $display("FAIL after_async_rst got cf=%0d lvl=%b flt=%b exp 0/1/000", bus.car_floor, bus.at_level, bus.fault_flags); end
    endtask

    task automatic test_random();
        int len, sel, cyc;
        bit up, dn, brk, op, cl, ob;
        logic [FLOORS-1:0] exp_fs;
        do_reset();
        cyc = 0;
        while (cyc < 6000) begin
            if (cyc % 1500 < 100 && cyc >= 1500 && cyc % 1500 == 0) do_reset();
            sel = $urandom_range(0, 11);
            len = $urandom_range(1, 150);
            up = 0; dn = 0; op = 0; cl = 0; ob = 0;
            brk = ($urandom_range(0, 9) == 0);
            case (sel)
                0, 1, 2, 3: up = 1;
                4, 5, 6, 7: dn = 1;
                8:          op = 1;
                9:          begin cl = 1; ob = ($urandom_range(0, 3) == 0); end
                10:         begin up = $urandom; dn = $urandom; op = $urandom; cl = $urandom; ob = $urandom; len = $urandom_range(1, 6); end
                default:    len = $urandom_range(1, 8);
            endcase
            for (int i = 0; i < len; i++) begin
                drive(up, dn, brk, op, cl, ob);
                step();
                cyc++;
                exp_fs = '0;
                exp_fs[m_land] = 1'b1;
                checks++; if (bus.floor_sensor !== exp_fs || bus.car_floor !== 3'(m_land)) begin errors++; $display("FAIL rnd_floor cyc %0d got fs=%b cf=%0d exp %b/%0d", cyc, bus.floor_sensor, bus.car_floor, exp_fs, m_land); end
                checks++; if (bus.at_level !== ((m_pos % TPF) == 0) || bus.car_moving !== m_mv) begin errors++; $display("FAIL rnd_motion cyc %0d got lvl=%b mov=%b exp pos=%0d mov=%b", cyc, bus.at_level, bus.car_moving, m_pos, m_mv); end
                checks++; if (bus.door_closed_sensor !== (m_door == 0) || bus.door_open_sensor !== (m_door == DOOR_TICKS)) begin errors++; $display("FAIL rnd_door cyc %0d got closed=%b open=%b exp door=%0d", cyc, bus.door_closed_sensor, bus.door_open_sensor, m_door); end
                checks++; if (bus.fault_flags !== m_flt) begin errors++; $display("FAIL rnd_faults cyc %0d got %b exp %b", cyc, bus.fault_flags, m_flt); end
            end
            // Periodic clean restart so faults do not saturate for the whole run.
            if (cyc / 1500 != (cyc - len) / 1500) do_reset();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_travel();
        test_door();
        test_interlock();
        test_conflict();
        test_reset_midtravel();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1);
    end
endmodule
